// File: rtl/setcc_pkg.sv
// Shared encodings for the set-condition compare unit: opcodes, FSM states, default sizes
// and the opcode-to-condition resolution helpers.
package setcc_pkg;

    localparam int SETCC_DEF_WIDTH = 32;
    localparam int SETCC_DEF_CHUNK = 8;

    // op_sel[3] selects a signed compare when signed support is built in
    localparam int SETCC_SIGNED_BIT = 3;

    typedef enum logic [2:0] {
        SETCC_SEQ  = 3'd0,
        SETCC_SNE  = 3'd1,
        SETCC_SLT  = 3'd2,
        SETCC_SGT  = 3'd3,
        SETCC_SLE  = 3'd4,
        SETCC_SGE  = 3'd5,
        SETCC_RSV6 = 3'd6,
        SETCC_RSV7 = 3'd7
    } setcc_op_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic setcc_is_rsvd(input logic [2:0] op);
        return (op == SETCC_RSV6) || (op == SETCC_RSV7);
    endfunction

    // Maps the compare opcode onto the Z flag and the less-than predicate
    function automatic logic setcc_resolve(input logic [2:0] op, input logic z, input logic lt);
        logic r;
        r = 1'b0;
        case (setcc_op_e'(op))
            SETCC_SEQ: r = z;
            SETCC_SNE: r = ~z;
            SETCC_SLT: r = lt;
            SETCC_SGT: r = ~lt & ~z;
            SETCC_SLE: r = lt | z;
            SETCC_SGE: r = ~lt;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/setcc_if.sv
// Issue-side request and writeback-side result channels of the set-condition compare unit.
interface setcc_if
    import setcc_pkg::*;
#(
    parameter int WIDTH = SETCC_DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       op_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] set_out;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic             op_err;

    modport master (
        output in_valid, op_a, op_b, op_sel, out_ready,
        input  in_ready, out_valid, set_out, flag_z, flag_c, flag_v, op_err
    );

    modport slave (
        input  in_valid, op_a, op_b, op_sel, out_ready,
        output in_ready, out_valid, set_out, flag_z, flag_c, flag_v, op_err
    );

endinterface

// File: rtl/setcc_chunk_adder.sv
// One CHUNK-bit slice of the A + ~B + 1 subtraction; reused every CALC cycle.
module setcc_chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, ~b} + {{CHUNK{1'b0}}, cin};
    end

endmodule

// File: rtl/setcc_compare_unit.sv
// Multi-cycle A-B compare producing Z/C/V flags and a 0/1 set value for SEQ..SGE.
// Build option: define SETCC_SIGNED_CMP_EN to honour op_sel[3] (signed compares) and drive flag_v.
module setcc_compare_unit
    import setcc_pkg::*;
#(
    parameter int WIDTH = SETCC_DEF_WIDTH,
    parameter int CHUNK = SETCC_DEF_CHUNK
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    setcc_if.slave bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("setcc_compare_unit: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    logic [1:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             zacc_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;

    logic             set_q;
    logic             flag_z_q;
    logic             flag_c_q;
    logic             flag_v_q;
    logic             op_err_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] sum_w;
    logic             cout_w;

    logic             accept;
    logic             last_chunk;
    logic             z_fin;
    logic             c_fin;
    logic             v_fin;
    logic             lt_fin;

    assign accept     = (state_q == ST_IDLE) && bus.in_valid;
    assign last_chunk = (cnt_q == CNT_LAST);

    always_comb begin
        a_chunk = a_q[cnt_q*CHUNK +: CHUNK];
        b_chunk = b_q[cnt_q*CHUNK +: CHUNK];
    end

    setcc_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_adder (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_q),
        .sum  (sum_w),
        .cout (cout_w)
    );

    // Flag values as they stand on the edge that consumes the top chunk
    assign z_fin = ~(zacc_q | (|sum_w));
    assign c_fin = cout_w;

`ifdef SETCC_SIGNED_CMP_EN
    logic sgn_q;
    logic n_fin;

    assign n_fin  = sum_w[CHUNK-1];
    assign v_fin  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (n_fin ^ a_q[WIDTH-1]);
    assign lt_fin = sgn_q ? (n_fin ^ v_fin) : ~c_fin;

    always_ff @(posedge clk) begin
        if (accept && !flush) begin
            sgn_q <= bus.op_sel[SETCC_SIGNED_BIT];
        end
    end
`else
    logic sign_unused;

    assign sign_unused = bus.op_sel[SETCC_SIGNED_BIT];
    assign v_fin       = 1'b0;
    assign lt_fin      = ~c_fin;
`endif

    // Operands are data only: captured at the accept edge, never reset
    always_ff @(posedge clk) begin
        if (accept && !flush) begin
            a_q  <= bus.op_a;
            b_q  <= bus.op_b;
            op_q <= bus.op_sel[2:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b1;
            zacc_q   <= 1'b0;
            set_q    <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            flag_v_q <= 1'b0;
            op_err_q <= 1'b0;
        end else if (flush) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        state_q <= ST_CALC;
                        cnt_q   <= '0;
                        carry_q <= 1'b1;
                        zacc_q  <= 1'b0;
                    end
                end
                ST_CALC: begin
                    carry_q <= cout_w;
                    zacc_q  <= zacc_q | (|sum_w);
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_chunk) begin
                        state_q  <= ST_DONE;
                        cnt_q    <= '0;
                        set_q    <= setcc_resolve(op_q, z_fin, lt_fin);
                        flag_z_q <= z_fin;
                        flag_c_q <= c_fin;
                        flag_v_q <= v_fin;
                        op_err_q <= setcc_is_rsvd(op_q);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.set_out   = {{(WIDTH-1){1'b0}}, set_q};
    assign bus.flag_z    = flag_z_q;
    assign bus.flag_c    = flag_c_q;
    assign bus.flag_v    = flag_v_q;
    assign bus.op_err    = op_err_q;

endmodule

// File: tb/tb_setcc_compare_unit.sv
// Bench for setcc_compare_unit: directed vector table, corner sequences and randomized ops
// checked against an arithmetic reference model.
module tb_setcc_compare_unit;
    import setcc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    setcc_if #(.WIDTH(32)) bus ();

    setcc_compare_unit #(
        .WIDTH (32),
        .CHUNK (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic set;
        logic z;
        logic c;
        logic v;
        logic err;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        res_t        exp;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference model: direct integer comparisons rather than flag algebra
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        res_t   r;
        logic   lt;
        logic   gt;
        longint sd;
        r.z = (a == b);
        r.c = (a >= b);
        sd  = longint'($signed(a)) - longint'($signed(b));
`ifdef SETCC_SIGNED_CMP_EN
        r.v = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        lt  = op[3] ? ($signed(a) < $signed(b)) : (a < b);
        gt  = op[3] ? ($signed(a) > $signed(b)) : (a > b);
`else
        r.v = 1'b0;
        lt  = (a < b);
        gt  = (a > b);
`endif
        case (op[2:0])
            3'd0:    r.set = (a == b);
            3'd1:    r.set = (a != b);
            3'd2:    r.set = lt;
            3'd3:    r.set = gt;
            3'd4:    r.set = !gt;
            3'd5:    r.set = !lt;
            default: r.set = 1'b0;
        endcase
        r.err = (op[2:0] >= 3'd6);
        return r;
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        @(negedge clk);
        bus.op_a      = a;
        bus.op_b      = b;
        bus.op_sel    = op;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op_a     = $urandom();
        bus.op_b     = $urandom();
        bus.op_sel   = 4'($urandom());
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_out(input string nm, input res_t e, input int lat);
        chk({nm, " latency"}, 64'(lat), 64'd4);
        chk({nm, " set_out"}, 64'(bus.set_out), {63'd0, e.set});
        chk({nm, " flag_z"}, 64'(bus.flag_z), 64'(e.z));
        chk({nm, " flag_c"}, 64'(bus.flag_c), 64'(e.c));
        chk({nm, " flag_v"}, 64'(bus.flag_v), 64'(e.v));
        chk({nm, " op_err"}, 64'(bus.op_err), 64'(e.err));
    endtask

    task automatic release_out(input string nm);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({nm, " back to idle {out_valid,in_ready}"}, 64'({bus.out_valid, bus.in_ready}), 64'b01);
    endtask

    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input res_t e);
        int lat;
        start_op(a, b, op);
        wait_done(lat);
        check_out(nm, e, lat);
        release_out(nm);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic        ok;
        logic [31:0] held;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rop;
        res_t        e;

        //               a              b              op     set  z    c    v    err
        tbl[0] = '{32'd5,        32'd5,        4'd0, '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
        tbl[1] = '{32'd5,        32'd5,        4'd1, '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0}};
        tbl[2] = '{32'd3,        32'd7,        4'd2, '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
        tbl[3] = '{32'd7,        32'd3,        4'd3, '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0}};
        tbl[4] = '{32'd7,        32'd3,        4'd4, '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
        tbl[5] = '{32'hFFFFFFFF, 32'd1,        4'd2, '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
        tbl[6] = '{32'd9,        32'd9,        4'd5, '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
        tbl[7] = '{32'd0,        32'hFFFFFFFF, 4'd3, '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        tbl[8] = '{32'h00000100, 32'h00000001, 4'd4, '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
        tbl[9] = '{32'd5,        32'd5,        4'd7, '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1}};

        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.op_sel    = '0;

        @(negedge clk);
        chk("reset in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset outputs {set,z,c,v,err}",
            64'({bus.set_out, bus.flag_z, bus.flag_c, bus.flag_v, bus.op_err}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp);
        end

`ifdef SETCC_SIGNED_CMP_EN
        run_op("signed SLT -1<1", 32'hFFFFFFFF, 32'd1, 4'hA, '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        run_op("signed SGE min>=1", 32'h80000000, 32'd1, 4'hD, '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
`else
        run_op("sign bit ignored SLT", 32'hFFFFFFFF, 32'd1, 4'hA, '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        run_op("sign bit ignored SGE", 32'h80000000, 32'd1, 4'hD, '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
`endif

        // Backpressure: result held, busy, new requests ignored
        start_op(32'd100, 32'd200, 4'd2);
        wait_done(lat);
        check_out("backpressure", model(32'd100, 32'd200, 4'd2), lat);
        held = bus.set_out;
        ok   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.op_a     = $urandom();
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b1 || bus.set_out !== held || bus.in_ready !== 1'b0) ok = 1'b0;
        end
        bus.in_valid = 1'b0;
        chk("backpressure hold stable", 64'(ok), 64'd1);
        release_out("backpressure");

        // Flush at cnt==2 drops the transaction
        start_op(32'd20, 32'd3, 4'd2);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush -> idle {out_valid,in_ready}", 64'({bus.out_valid, bus.in_ready}), 64'b01);
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) ok = 1'b0;
        end
        chk("flush nothing emitted", 64'(ok), 64'd1);
        run_op("after flush SGE 9,9", 32'd9, 32'd9, 4'd5, '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0});

        // Reserved op, then async reset while in DONE
        start_op(32'd5, 32'd5, 4'd6);
        wait_done(lat);
        check_out("reserved op6", '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1}, lat);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst in DONE {out_valid,in_ready}", 64'({bus.out_valid, bus.in_ready}), 64'b01);
        chk("async rst in DONE outputs",
            64'({bus.set_out, bus.flag_z, bus.flag_c, bus.flag_v, bus.op_err}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after rst SGT 7,3", 32'd7, 32'd3, 4'd3, '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0});

        for (int i = 0; i < 40; i++) begin
            ra  = $urandom();
            rb  = $urandom();
            rop = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 4))
                0: rb = ra;
                1: rb = ra ^ 32'h80000000;
                2: rb = ra + 32'd1;
                default: ;
            endcase
            e = model(ra, rb, rop);
            run_op($sformatf("rand%0d a=%0h b=%0h op=%0h", i, ra, rb, rop), ra, rb, rop, e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
